alu_4bit: RTL and testbench



---
 rtl/alu_4bit.sv | 122 ++++++++++++
 tb/tb_alu_4bit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_4bit.sv
// 4-bit MIPS-style ALU slice: AND, OR, ADD, SUB, SLT on two's-complement operands.
// Per-bit slices feed a carry-lookahead unit; group G/P are exported for cascading.
// Operands are sampled on the rising edge and every output is registered (1-cycle latency).
// Optional feature: define ALU4_ZERO_FLAG_EN to add the registered 'zero' output.
module alu_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       cout,
    output logic       G,
    output logic       P,
    output logic       set,
`ifdef ALU4_ZERO_FLAG_EN
    output logic       zero,
`endif
    output logic       overflow
);

    localparam int unsigned W = 4;

    logic           binvert;
    logic [W-1:0]   bb;
    logic [W-1:0]   g;
    logic [W-1:0]   p;
    logic [W-1:0]   sum;
    logic [W-1:0]   and_r;
    logic [W-1:0]   or_r;
    logic [W:0]     c;
    logic           grp_g_c;
    logic           grp_p_c;
    logic           ovf_c;
    logic           set_c;
    logic [W-1:0]   result_c;

    // op[2] both inverts B and supplies the adder carry-in
    assign binvert = op[2];

    // Bit slices: conditional B inversion, generate/propagate, logic results, sum bit
    for (genvar i = 0; i < int'(W); i++) begin : g_slice
        assign bb[i]    = b[i] ^ binvert;
        assign g[i]     = a[i] & bb[i];
        assign p[i]     = a[i] ^ bb[i];
        assign and_r[i] = a[i] & bb[i];
        assign or_r[i]  = a[i] | bb[i];
        assign sum[i]   = p[i] ^ c[i];
    end

    // Carry-lookahead unit: every carry computed directly from g/p and carry-in
    always_comb begin
        c       = '0;
        grp_g_c = 1'b0;
        grp_p_c = 1'b0;

        c[0] = binvert;
        c[1] = g[0]
             | (p[0] & binvert);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & binvert);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & binvert);

        grp_g_c = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
        grp_p_c = p[3] & p[2] & p[1] & p[0];

        c[4] = grp_g_c | (grp_p_c & binvert);
    end

    // Signed overflow from the MSB carries; set is the corrected sign (true signed less-than)
    assign ovf_c = c[3] ^ c[4];
    assign set_c = sum[3] ^ ovf_c;

    // Function select; adder flags are left unmasked for the logic ops
    always_comb begin
        result_c = '0;
        unique case (op[1:0])
            2'b00:   result_c = and_r;
            2'b01:   result_c = or_r;
            2'b10:   result_c = sum;
            default: result_c = {3'b000, set_c};
        endcase
    end

    // Output registers; reset clears any in-flight result immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            cout     <= 1'b0;
            G        <= 1'b0;
            P        <= 1'b0;
            set      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            result   <= result_c;
            cout     <= c[4];
            G        <= grp_g_c;
            P        <= grp_p_c;
            set      <= set_c;
            overflow <= ovf_c;
        end
    end

`ifdef ALU4_ZERO_FLAG_EN
    // Registered zero-result flag; an all-zero reset result reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b1;
        end else begin
            zero <= (result_c == 4'b0000);
        end
    end
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: vector table applied back-to-back plus reset/latency sequences.
// Honours ALU4_ZERO_FLAG_EN when defined.
module tb_alu_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] result;
    logic       cout;
    logic       G;
    logic       P;
    logic       set;
    logic       overflow;
`ifdef ALU4_ZERO_FLAG_EN
    logic       zero;
`endif

    int checks;
    int errors;

    alu_4bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (result),
        .cout     (cout),
        .G        (G),
        .P        (P),
        .set      (set),
`ifdef ALU4_ZERO_FLAG_EN
        .zero     (zero),
`endif
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       co;
        logic       gg;
        logic       pp;
        logic       st;
        logic       ov;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    // Compare every registered output against the expected record
    task automatic check_out(input string name, input vec_t e);
        logic [8:0] act;
        logic [8:0] exp;
        act = {result, cout, G, P, set, overflow};
        exp = {e.res, e.co, e.gg, e.pp, e.st, e.ov};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got res=%b cout=%b G=%b P=%b set=%b ovf=%b, want res=%b cout=%b G=%b P=%b set=%b ovf=%b",
                     name, result, cout, G, P, set, overflow,
                     e.res, e.co, e.gg, e.pp, e.st, e.ov);
        end
`ifdef ALU4_ZERO_FLAG_EN
        checks++;
        if (zero !== (e.res == 4'b0000)) begin
            errors++;
            $display("FAIL %s zero: got %b want %b", name, zero, (e.res == 4'b0000));
        end
`endif
    endtask

    initial begin
        vec_t zrec;
        checks = 0;
        errors = 0;
        zrec   = '0;

        //             op      a        b        res      co    G     P     set   ovf
        vecs[0]  = '{3'b100, 4'b1111, 4'b0010, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'b010, 4'b0111, 4'b0111, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{3'b010, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{3'b110, 4'b1001, 4'b0111, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{3'b110, 4'b1001, 4'b1001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b111, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'b111, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b111, 4'b1001, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'b111, 4'b1111, 4'b1001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b111, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b000, 4'b1100, 4'b1010, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{3'b001, 4'b0101, 4'b0011, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b101, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b011, 4'b0110, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{3'b010, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'b010, 4'b0101, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset with live inputs: outputs must sit at their reset values
        rst_n = 1'b0;
        op    = vecs[15].op;
        a     = vecs[15].a;
        b     = vecs[15].b;
        repeat (2) @(posedge clk);
        #1 check_out("reset_hold", zrec);

        // Release on a falling edge; nothing moves until the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_out("post_release_pre_edge", zrec);

        // Table vectors applied back-to-back, one per cycle
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            op = vecs[i].op;
            a  = vecs[i].a;
            b  = vecs[i].b;
            @(posedge clk);
            #1 check_out($sformatf("vec%0d", i), vecs[i]);
        end

        // Latency: an input change between edges must not reach the outputs
        @(negedge clk);
        op = vecs[1].op;
        a  = vecs[1].a;
        b  = vecs[1].b;
        #1 check_out("latency_hold", vecs[15]);
        @(posedge clk);
        #1 check_out("latency_update", vecs[1]);

        // Mid-cycle reset discards the registered result at once
        @(negedge clk);
        op = vecs[15].op;
        a  = vecs[15].a;
        b  = vecs[15].b;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_out("async_reset_immediate", zrec);
        @(posedge clk);
        #1 check_out("async_reset_held", zrec);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_out("release_no_edge", zrec);
        @(posedge clk);
        #1 check_out("first_sample_after_release", vecs[15]);

        // Zero-result path after recovery
        @(negedge clk);
        op = vecs[4].op;
        a  = vecs[4].a;
        b  = vecs[4].b;
        @(posedge clk);
        #1 check_out("sub_equal_after_reset", vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
